// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the N-stage MIPS pipeline: drives pipe register enables/clears and PC enable,
// tracks multi-cycle load-use bubbles, dcache-miss freezes with a watchdog, and stall/redirect perf counters.
module pipeline_hazard_ctrl #(
    parameter int NSTAGES     = 5,
    parameter int REGW        = 5,
    parameter int LU_STALL    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNTW        = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ihit,
    input  logic                 dmem_req,
    input  logic                 dhit,
    input  logic                 redirect,
    input  logic                 halt,
    input  logic                 ex_is_load,
    input  logic [REGW-1:0]      ex_wsel,
    input  logic [REGW-1:0]      id_rsel1,
    input  logic [REGW-1:0]      id_rsel2,
    input  logic                 id_use1,
    input  logic                 id_use2,
    output logic                 pc_en,
    output logic [NSTAGES-2:0]   pipe_en,
    output logic [NSTAGES-2:0]   flush,
    output logic [1:0]           state,
    output logic                 err_timeout,
    output logic [CNTW-1:0]      stall_cnt,
    output logic [CNTW-1:0]      flush_cnt
);

    localparam int NPIPE = NSTAGES - 1;
    localparam logic [NPIPE-1:0] FLUSH_MASK   = NPIPE'((1 << FLUSH_DEPTH) - 1);
    localparam logic [NPIPE-1:0] BUBBLE_FLUSH = NPIPE'(2);
    localparam logic [NPIPE-1:0] BUBBLE_EN    = ~NPIPE'(1);
    localparam logic [2:0]       LU_CNT_INIT  = 3'(LU_STALL - 1);
    localparam logic [31:0]      WD_LIMIT     = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_WAIT  = 2'b01,
        MEM_WAIT = 2'b10,
        HALTED   = 2'b11
    } state_t;

    state_t      cur_state, nxt_state, ret_state, nxt_ret, eff_state;
    logic [2:0]  lu_cnt, nxt_lu;
    logic [31:0] wd_cnt;
    logic        load_use;
    logic        redirect_evt;

    assign state = cur_state;

    assign load_use = ex_is_load && (ex_wsel != '0) &&
                      ((id_use1 && (id_rsel1 == ex_wsel)) || (id_use2 && (id_rsel2 == ex_wsel)));

    // When a dcache wait completes, the hazard rules are evaluated as if still in the saved state.
    always_comb begin
        pc_en        = 1'b0;
        pipe_en      = '0;
        flush        = '0;
        nxt_state    = cur_state;
        nxt_ret      = ret_state;
        nxt_lu       = lu_cnt;
        redirect_evt = 1'b0;
        eff_state    = (cur_state == MEM_WAIT) ? ret_state : cur_state;

        if (cur_state == HALTED || halt) begin
            nxt_state = HALTED;
        end else if (err_timeout || ((cur_state == MEM_WAIT) ? !dhit : (dmem_req && !dhit))) begin
            nxt_state = MEM_WAIT;
            if (cur_state != MEM_WAIT) nxt_ret = cur_state;
        end else if (redirect) begin
            pc_en        = 1'b1;
            pipe_en      = '1;
            flush        = FLUSH_MASK;
            nxt_state    = RUN;
            nxt_lu       = '0;
            redirect_evt = 1'b1;
        end else if (eff_state == LU_WAIT || load_use) begin
            pipe_en = BUBBLE_EN;
            flush   = BUBBLE_FLUSH;
            if (eff_state == LU_WAIT) begin
                if (lu_cnt <= 3'd1) begin
                    nxt_state = RUN;
                    nxt_lu    = '0;
                end else begin
                    nxt_state = LU_WAIT;
                    nxt_lu    = lu_cnt - 3'd1;
                end
            end else if (LU_STALL > 1) begin
                nxt_state = LU_WAIT;
                nxt_lu    = LU_CNT_INIT;
            end else begin
                nxt_state = RUN;
            end
        end else if (!ihit) begin
            pipe_en   = BUBBLE_EN;
            flush     = BUBBLE_FLUSH;
            nxt_state = RUN;
        end else begin
            pc_en     = 1'b1;
            pipe_en   = '1;
            nxt_state = RUN;
        end

        if (!nRST) begin
            pc_en   = 1'b0;
            pipe_en = '0;
            flush   = '1;
        end
    end

    // The watchdog saturates at its limit so a long freeze cannot wrap it back to zero.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cur_state   <= RUN;
            ret_state   <= RUN;
            lu_cnt      <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            ret_state <= nxt_ret;
            lu_cnt    <= nxt_lu;

            if (nxt_state != MEM_WAIT)
                wd_cnt <= '0;
            else if (TIMEOUT != 0 && cur_state == MEM_WAIT && !dhit && wd_cnt != WD_LIMIT)
                wd_cnt <= wd_cnt + 32'd1;

            if (TIMEOUT != 0 && cur_state == MEM_WAIT && wd_cnt == WD_LIMIT)
                err_timeout <= 1'b1;

            if (!pc_en && cur_state != HALTED && !halt && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;

            if (redirect_evt && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a LU_STALL=3/TIMEOUT=8 instance plus a LU_STALL=1,
// CNTW=2, watchdog-off instance that shares the same inputs.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] IDLE    = 5'b10000;   // {ihit, dmem_req, dhit, redirect, halt}
    localparam logic [4:0] BUB     = 5'b00000;
    localparam logic [4:0] MISS    = 5'b11000;
    localparam logic [4:0] HIT     = 5'b11100;
    localparam logic [4:0] RDR     = 5'b10010;
    localparam logic [4:0] RDR_NOI = 5'b00010;
    localparam logic [4:0] HLT     = 5'b10001;
    localparam logic [2:0] NOLD    = 3'b000;     // {ex_is_load, id_use1, id_use2}
    localparam logic [2:0] LD1     = 3'b110;
    localparam logic [2:0] LD2     = 3'b101;
    localparam logic [2:0] LDNOUSE = 3'b100;
    localparam logic [3:0] P_ALL = 4'b1111, P_BUB = 4'b1110, P_OFF = 4'b0000;
    localparam logic [3:0] F_NONE = 4'b0000, F_BUB = 4'b0010, F_RDR = 4'b0011, F_ALL = 4'b1111;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dmem_req, dhit, redirect, halt, ex_is_load, id_use1, id_use2;
    logic [4:0]  ex_wsel, id_rsel1, id_rsel2;
    logic        pc_en, err_timeout;
    logic [3:0]  pipe_en, flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_en_b, err_timeout_b;
    logic [3:0]  pipe_en_b, flush_b;
    logic [1:0]  state_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(
        .NSTAGES(5), .REGW(5), .LU_STALL(3), .FLUSH_DEPTH(2), .TIMEOUT(8), .CNTW(32)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .redirect(redirect), .halt(halt), .ex_is_load(ex_is_load), .ex_wsel(ex_wsel),
        .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_use1(id_use1), .id_use2(id_use2),
        .pc_en(pc_en), .pipe_en(pipe_en), .flush(flush), .state(state),
        .err_timeout(err_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(
        .NSTAGES(5), .REGW(5), .LU_STALL(1), .FLUSH_DEPTH(2), .TIMEOUT(0), .CNTW(2)
    ) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .redirect(redirect), .halt(halt), .ex_is_load(ex_is_load), .ex_wsel(ex_wsel),
        .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_use1(id_use1), .id_use2(id_use2),
        .pc_en(pc_en_b), .pipe_en(pipe_en_b), .flush(flush_b), .state(state_b),
        .err_timeout(err_timeout_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input logic rst_n, input logic [4:0] ctrl, input logic [2:0] ld,
                                 input logic [4:0] wsel, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge CLK);
        nRST = rst_n;
        {ihit, dmem_req, dhit, redirect, halt} = ctrl;
        {ex_is_load, id_use1, id_use2} = ld;
        ex_wsel  = wsel;
        id_rsel1 = r1;
        id_rsel2 = r2;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_pc, input logic [3:0] exp_pipe,
                               input logic [3:0] exp_flush, input logic [1:0] exp_state);
        total++;
        assert ({pc_en, pipe_en, flush, state} === {exp_pc, exp_pipe, exp_flush, exp_state})
        else begin
            bad++;
            $error("[TB] FAIL %s: pc/pipe/flush/state got %b/%b/%b/%b expected %b/%b/%b/%b", tag,
                   pc_en, pipe_en, flush, state, exp_pc, exp_pipe, exp_flush, exp_state);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        nRST = 1'b0;
        {ihit, dmem_req, dhit, redirect, halt} = IDLE;
        {ex_is_load, id_use1, id_use2} = NOLD;
        ex_wsel = '0; id_rsel1 = '0; id_rsel2 = '0;

        // reset held for two edges
        applyStimulus(1'b0, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("reset_outputs", 1'b0, P_OFF, F_ALL, 2'b00);
        checkValue("reset_stall_cnt", stall_cnt, 32'd0);
        checkValue("reset_flush_cnt", flush_cnt, 32'd0);
        checkValue("reset_err", 32'(err_timeout), 32'd0);

        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("run_ihit", 1'b1, P_ALL, F_NONE, 2'b00);
        applyStimulus(1'b1, BUB, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("icache_miss_bubble", 1'b0, P_BUB, F_BUB, 2'b00);

        // load-use on rsel1: three bubble cycles with LU_STALL=3, one with LU_STALL=1
        applyStimulus(1'b1, IDLE, LD1, 5'd5, 5'd5, 5'd0);
        checkOutput("lu_detect", 1'b0, P_BUB, F_BUB, 2'b00);
        checkValue("lu1_detect_pc", 32'(pc_en_b), 32'd0);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("lu_wait_2", 1'b0, P_BUB, F_BUB, 2'b01);
        checkValue("lu1_no_wait_pc", 32'(pc_en_b), 32'd1);
        checkValue("lu1_no_wait_state", 32'(state_b), 32'd0);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("lu_wait_1", 1'b0, P_BUB, F_BUB, 2'b01);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("lu_back_to_run", 1'b1, P_ALL, F_NONE, 2'b00);
        checkValue("stall_after_lu", stall_cnt, 32'd4);

        // non-hazards: destination $zero, and source not actually read
        applyStimulus(1'b1, IDLE, LD1, 5'd0, 5'd0, 5'd0);
        checkOutput("lu_wsel_zero", 1'b1, P_ALL, F_NONE, 2'b00);
        applyStimulus(1'b1, IDLE, LDNOUSE, 5'd5, 5'd5, 5'd3);
        checkOutput("lu_use_off", 1'b1, P_ALL, F_NONE, 2'b00);

        // redirect beats a simultaneous load-use (via rsel2) and a missing fetch
        applyStimulus(1'b1, RDR_NOI, LD2, 5'd7, 5'd5, 5'd7);
        checkOutput("redirect_wins", 1'b1, P_ALL, F_RDR, 2'b00);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkValue("flush_cnt_1", flush_cnt, 32'd1);
        checkValue("stall_unchanged", stall_cnt, 32'd4);

        // redirect during LU_WAIT abandons the remaining bubbles
        applyStimulus(1'b1, IDLE, LD1, 5'd5, 5'd5, 5'd0);
        checkOutput("lu_detect_2", 1'b0, P_BUB, F_BUB, 2'b00);
        applyStimulus(1'b1, RDR, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("redirect_in_lu_wait", 1'b1, P_ALL, F_RDR, 2'b01);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("run_after_redirect", 1'b1, P_ALL, F_NONE, 2'b00);
        applyStimulus(1'b1, RDR, NOLD, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, RDR, NOLD, 5'd0, 5'd0, 5'd0);

        // dcache miss inside LU_WAIT: freeze, then resume with lu_cnt preserved
        applyStimulus(1'b1, IDLE, LD1, 5'd5, 5'd5, 5'd0);
        checkOutput("lu_detect_3", 1'b0, P_BUB, F_BUB, 2'b00);
        applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("dmiss_freeze_enter", 1'b0, P_OFF, F_NONE, 2'b01);
        applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("mem_wait_freeze", 1'b0, P_OFF, F_NONE, 2'b10);
        applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, HIT, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("dhit_resume_lu", 1'b0, P_BUB, F_BUB, 2'b10);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("lu_wait_last", 1'b0, P_BUB, F_BUB, 2'b01);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("run_after_mem_wait", 1'b1, P_ALL, F_NONE, 2'b00);
        checkValue("stall_cnt_12", stall_cnt, 32'd12);
        checkValue("flush_cnt_4", flush_cnt, 32'd4);

        // watchdog: wd_cnt reaches 8 after 8 MEM_WAIT cycles, err latches at the next edge
        applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("dmiss_run", 1'b0, P_OFF, F_NONE, 2'b00);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        checkValue("err_before_limit", 32'(err_timeout), 32'd0);
        applyStimulus(1'b1, MISS, NOLD, 5'd0, 5'd0, 5'd0);
        checkValue("err_at_limit", 32'(err_timeout), 32'd0);
        applyStimulus(1'b1, HIT, NOLD, 5'd0, 5'd0, 5'd0);
        checkValue("err_set", 32'(err_timeout), 32'd1);
        checkOutput("err_freeze_dhit", 1'b0, P_OFF, F_NONE, 2'b10);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("err_freeze_idle", 1'b0, P_OFF, F_NONE, 2'b10);
        applyStimulus(1'b1, HLT, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("halt_request", 1'b0, P_OFF, F_NONE, 2'b10);
        applyStimulus(1'b1, IDLE, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("halted", 1'b0, P_OFF, F_NONE, 2'b11);
        checkValue("err_sticky", 32'(err_timeout), 32'd1);
        applyStimulus(1'b1, RDR, NOLD, 5'd0, 5'd0, 5'd0);
        checkOutput("halted_ignores_redirect", 1'b0, P_OFF, F_NONE, 2'b11);
        checkValue("stall_frozen_halted", stall_cnt, 32'd24);
        checkValue("flush_cnt_final", flush_cnt, 32'd4);

        // second instance: counters saturate at 3, watchdog disabled
        checkValue("b_stall_sat", 32'(stall_cnt_b), 32'd3);
        checkValue("b_flush_sat", 32'(flush_cnt_b), 32'd3);
        checkValue("b_no_timeout", 32'(err_timeout_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
